// File: rtl/ram64_arbiter_pkg.sv
// Shared constants and state encoding for the ram64_arbiter block.
// Widths here must match the attached 64x16 RAM bank.
package ram64_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;

    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

    // Last word of the bank; the clear sequencer stops after writing it.
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

endpackage

// File: rtl/ram64_arbiter_if.sv
// Requester-side bus of ram64_arbiter: both ports' request, write data,
// grant and registered read-data signals.
interface ram64_arbiter_if;
    import ram64_arbiter_pkg::*;

    // Handshake: reqN is held, with weN/addrN/wdataN stable, until gntN is
    // seen high; the transaction commits at that clock edge. A read returns
    // rdataN with a one-cycle rvalidN pulse in the following cycle.
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              rvalid0;
    logic              rvalid1;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1
    );

endinterface

// File: rtl/ram64_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with a one-bit priority pointer.
// The pointer names the port that wins the next tie.
module rr_arb2
    import ram64_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       ptr
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
            // Winner hands priority to the other port; no grant leaves it alone.
            if (gnt[PORT_CPU]) begin
                ptr_d = 1'b1;
            end else if (gnt[PORT_DMA]) begin
                ptr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/ram64_arbiter.sv
// ram64_arbiter: round-robin sharing of one 64x16 RAM between a CPU and a DMA port.
// Define RAM64_ARBITER_CLEAR_EN to fill the bank with CLEAR_VAL after every reset.
module ram64_arbiter
    import ram64_arbiter_pkg::*;
#(
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    ram64_arbiter_if.slave    bus,
    output logic              busy,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_out,
    output state_t            dbg_state,
    output logic              dbg_ptr
);

`ifdef RAM64_ARBITER_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_SERVE;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_in_q, mem_in_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [1:0]        req_vec;
    logic [1:0]        gnt_vec;
    logic              arb_en;

`ifdef RAM64_ARBITER_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

    assign req_vec = {bus.req1, bus.req0};
    // Gating with rst_n keeps grants and RAM writes off while reset is held.
    assign arb_en  = rst_n && (state_q == ST_SERVE);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   (req_vec),
        .gnt   (gnt_vec),
        .ptr   (dbg_ptr)
    );

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_in_d   = mem_in_q;
        mem_load   = 1'b0;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
`ifdef RAM64_ARBITER_CLEAR_EN
        clr_cnt_d  = clr_cnt_q;
        busy       = 1'b0;
`endif
        case (state_q)
            ST_CLEAR: begin
`ifdef RAM64_ARBITER_CLEAR_EN
                if (rst_n) begin
                    busy       = 1'b1;
                    mem_load   = 1'b1;
                    mem_addr_d = clr_cnt_q;
                    mem_in_d   = CLEAR_VAL;
                    clr_cnt_d  = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d = ST_SERVE;
                    end
                end
`else
                // Never entered without the sequencer; fall straight into SERVE.
                mem_in_d = CLEAR_VAL;
                state_d  = ST_SERVE;
`endif
            end
            default: begin
                if (gnt_vec[PORT_CPU]) begin
                    mem_addr_d = bus.addr0;
                    if (bus.we0) begin
                        mem_load = 1'b1;
                        mem_in_d = bus.wdata0;
                    end else begin
                        rvalid0_d = 1'b1;
                    end
                end else if (gnt_vec[PORT_DMA]) begin
                    mem_addr_d = bus.addr1;
                    if (bus.we1) begin
                        mem_load = 1'b1;
                        mem_in_d = bus.wdata1;
                    end else begin
                        rvalid1_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Read capture kept apart from the address mux: mem_out is a function of mem_addr.
    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (rvalid0_d) begin
            rdata0_d = mem_out;
        end
        if (rvalid1_d) begin
            rdata1_d = mem_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RESET_STATE;
            mem_addr_q <= '0;
            mem_in_q   <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_in_q   <= mem_in_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

`ifdef RAM64_ARBITER_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt_q <= '0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
        end
    end
`else
    assign busy = 1'b0;
`endif

    // Unregistered address/data: the RAM sees this cycle's choice before the edge.
    assign mem_addr    = mem_addr_d;
    assign mem_in      = mem_in_d;
    assign dbg_state   = state_q;

    assign bus.gnt0    = gnt_vec[PORT_CPU];
    assign bus.gnt1    = gnt_vec[PORT_DMA];
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_ram64_arbiter.sv
// Self-checking bench for ram64_arbiter: directed scenarios plus random traffic
// against a word-array memory model and a per-port expected-read queue.
module tb_ram64_arbiter;
    import ram64_arbiter_pkg::*;

    localparam logic [DATA_W-1:0] CLR = 16'h0000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              busy;
    logic [DATA_W-1:0] mem_in;
    logic              mem_load;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_out;
    state_t            dbg_state;
    logic              dbg_ptr;

    ram64_arbiter_if bus_if();

    ram64_arbiter #(.CLEAR_VAL(CLR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .busy      (busy),
        .mem_in    (mem_in),
        .mem_load  (mem_load),
        .mem_addr  (mem_addr),
        .mem_out   (mem_out),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // ---------------- clock / RAM bank ----------------
    always #5 clk = ~clk;

    logic [DATA_W-1:0] ram [64];
    assign mem_out = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_load) ram[mem_addr] <= mem_in;
    end

    // ---------------- scoreboard / model state ----------------
    int                n_checks = 0;
    int                n_fail = 0;
    logic [DATA_W-1:0] exp_mem [64];
    logic [DATA_W-1:0] exp_q0[$];
    logic [DATA_W-1:0] exp_q1[$];
    logic              m_ptr;
    logic [ADDR_W-1:0] m_last_addr;
    logic [DATA_W-1:0] m_rdata0, m_rdata1;
    int                last_g;
    logic              obs_g0, obs_g1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (p == 0) begin
            bus_if.req0 = r; bus_if.we0 = w; bus_if.addr0 = a; bus_if.wdata0 = d;
        end else begin
            bus_if.req1 = r; bus_if.we1 = w; bus_if.addr1 = a; bus_if.wdata1 = d;
        end
    endtask

    task automatic model_reset();
        m_ptr       = 1'b0;
        m_last_addr = '0;
        m_rdata0    = '0;
        m_rdata1    = '0;
        last_g      = -1;
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // One served cycle: entered at a negedge with inputs already driven.
    task automatic do_cycle();
        int   g;
        logic rv0, rv1;
        #1;
        g = -1;
        if (bus_if.req0 && bus_if.req1) g = m_ptr ? 1 : 0;
        else if (bus_if.req0)           g = 0;
        else if (bus_if.req1)           g = 1;
        obs_g0 = bus_if.gnt0;
        obs_g1 = bus_if.gnt1;
        check_eq("gnt0", bus_if.gnt0, 32'(g == 0));
        check_eq("gnt1", bus_if.gnt1, 32'(g == 1));
        check_eq("busy", busy, 0);
        rv0 = 1'b0;
        rv1 = 1'b0;
        if (g == 0) begin
            check_eq("mem_addr", mem_addr, bus_if.addr0);
            check_eq("mem_load", mem_load, bus_if.we0);
            if (bus_if.we0) begin
                check_eq("mem_in", mem_in, bus_if.wdata0);
                exp_mem[bus_if.addr0] = bus_if.wdata0;
            end else begin
                exp_q0.push_back(exp_mem[bus_if.addr0]);
                rv0 = 1'b1;
            end
            m_last_addr = bus_if.addr0;
            m_ptr       = 1'b1;
        end else if (g == 1) begin
            check_eq("mem_addr", mem_addr, bus_if.addr1);
            check_eq("mem_load", mem_load, bus_if.we1);
            if (bus_if.we1) begin
                check_eq("mem_in", mem_in, bus_if.wdata1);
                exp_mem[bus_if.addr1] = bus_if.wdata1;
            end else begin
                exp_q1.push_back(exp_mem[bus_if.addr1]);
                rv1 = 1'b1;
            end
            m_last_addr = bus_if.addr1;
            m_ptr       = 1'b0;
        end else begin
            check_eq("idle_load", mem_load, 0);
            check_eq("idle_addr", mem_addr, m_last_addr);
        end
        last_g = g;
        @(posedge clk);
        #1;
        check_eq("rvalid0", bus_if.rvalid0, rv0);
        check_eq("rvalid1", bus_if.rvalid1, rv1);
        if (rv0 && exp_q0.size() > 0) m_rdata0 = exp_q0.pop_front();
        if (rv1 && exp_q1.size() > 0) m_rdata1 = exp_q1.pop_front();
        check_eq("rdata0", bus_if.rdata0, m_rdata0);
        check_eq("rdata1", bus_if.rdata1, m_rdata1);
        check_eq("ptr", dbg_ptr, m_ptr);
        @(negedge clk);
    endtask

    // Entered at a negedge right after rst_n rises; runs the fill when present.
    task automatic after_release();
        model_reset();
`ifdef RAM64_ARBITER_CLEAR_EN
        for (int i = 0; i < 64; i++) begin
            #1;
            check_eq("clr_busy", busy, 1);
            check_eq("clr_gnt0", bus_if.gnt0, 0);
            check_eq("clr_gnt1", bus_if.gnt1, 0);
            check_eq("clr_load", mem_load, 1);
            check_eq("clr_addr", mem_addr, i);
            check_eq("clr_in", mem_in, CLR);
            @(negedge clk);
        end
        for (int i = 0; i < 64; i++) exp_mem[i] = CLR;
        m_last_addr = LAST_ADDR;
`endif
    endtask

    task automatic idle_ports();
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saved_ptr;
        idle_ports();
        model_reset();
        for (int i = 0; i < 64; i++) exp_mem[i] = '0;

        // ---------------- reset state ----------------
        @(negedge clk);
        #1;
        check_eq("rst_gnt0", bus_if.gnt0, 0);
        check_eq("rst_rvalid0", bus_if.rvalid0, 0);
        check_eq("rst_rdata0", bus_if.rdata0, 0);
        check_eq("rst_load", mem_load, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_in", mem_in, 0);
        check_eq("rst_ptr", dbg_ptr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        after_release();

        // Known contents everywhere before any reads (random "garbage").
        for (int i = 0; i < 64; i++) begin
            idle_ports();
            set_port(i % 2, 1'b1, 1'b1, ADDR_W'(i), DATA_W'($urandom));
            do_cycle();
        end
        idle_ports();

        // ---------------- solo write / read ----------------
        set_port(0, 1'b1, 1'b1, 6'd5, 16'hBEEF);
        do_cycle();
        check_eq("solo_wr_gnt0", obs_g0, 1);
        set_port(0, 1'b1, 1'b0, 6'd5, 16'h0000);
        do_cycle();
        check_eq("solo_rd_gnt0", obs_g0, 1);
        check_eq("solo_rvalid0", bus_if.rvalid0, 1);
        check_eq("solo_rdata0", bus_if.rdata0, 16'hBEEF);
        idle_ports();

        // ---------------- write-then-read hazard ----------------
        set_port(1, 1'b1, 1'b1, 6'd63, 16'h1234);
        do_cycle();
        set_port(1, 1'b0, 1'b0, '0, '0);
        set_port(0, 1'b1, 1'b0, 6'd63, '0);
        do_cycle();
        check_eq("hazard_rdata0", bus_if.rdata0, 16'h1234);
        idle_ports();

        // ---------------- idle hold ----------------
        saved_ptr = m_ptr;
        for (int i = 0; i < 3; i++) do_cycle();
        check_eq("idle_ptr", dbg_ptr, saved_ptr);
        check_eq("idle_rvalid0", bus_if.rvalid0, 0);

        // ---------------- contention ----------------
        set_port(0, 1'b1, 1'b1, 6'd1, 16'h1111);
        do_cycle();
        idle_ports();
        set_port(1, 1'b1, 1'b1, 6'd2, 16'h2222);
        do_cycle();
        set_port(0, 1'b1, 1'b0, 6'd1, '0);
        set_port(1, 1'b1, 1'b0, 6'd2, '0);
        for (int k = 0; k < 4; k++) begin
            do_cycle();
            check_eq("cont_gnt0", obs_g0, 32'(k % 2 == 0));
            check_eq("cont_gnt1", obs_g1, 32'(k % 2 == 1));
            if (k % 2 == 0) check_eq("cont_rdata0", bus_if.rdata0, 16'h1111);
            else            check_eq("cont_rdata1", bus_if.rdata1, 16'h2222);
        end
        idle_ports();

        // ---------------- random traffic ----------------
        for (int c = 0; c < 500; c++) begin
            if (!bus_if.req0 || last_g == 0)
                set_port(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 3) == 0) ? 6'd63 : ADDR_W'($urandom_range(0, 7)),
                         DATA_W'($urandom));
            if (!bus_if.req1 || last_g == 1)
                set_port(1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 3) == 0) ? 6'd63 : ADDR_W'($urandom_range(0, 7)),
                         DATA_W'($urandom));
            do_cycle();
        end
        idle_ports();

        // Make rdata0 non-zero and rvalid0 high going into the reset.
        set_port(0, 1'b1, 1'b1, 6'd7, 16'hA5A5);
        do_cycle();
        set_port(0, 1'b1, 1'b0, 6'd7, '0);
        do_cycle();
        check_eq("pre_rst_rdata0", bus_if.rdata0, 16'hA5A5);

        // ---------------- reset mid-read ----------------
        set_port(0, 1'b1, 1'b0, 6'd0, '0);
        #1;
        check_eq("midrst_gnt0_pre", bus_if.gnt0, 1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_rvalid0", bus_if.rvalid0, 0);
        check_eq("midrst_rdata0", bus_if.rdata0, 0);
        check_eq("midrst_gnt0", bus_if.gnt0, 0);
        check_eq("midrst_ptr", dbg_ptr, 0);
        check_eq("midrst_load", mem_load, 0);
        @(posedge clk);
        #1;
        check_eq("midrst_rvalid0_held", bus_if.rvalid0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        after_release();

        // First served cycle after reset: req0 has been waiting the whole time.
        do_cycle();
        check_eq("post_rst_gnt0", obs_g0, 1);
        check_eq("post_rst_rd0", bus_if.rdata0, exp_mem[0]);
        set_port(0, 1'b1, 1'b0, 6'd63, '0);
        do_cycle();
        check_eq("post_rst_rd63", bus_if.rdata0, exp_mem[63]);
`ifdef RAM64_ARBITER_CLEAR_EN
        check_eq("clr_rd63_zero", bus_if.rdata0, CLR);
`endif
        idle_ports();
        do_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
